// File: rtl/xnorpop_pkg.sv
// Shared constants, FSM encoding and dot-product helper for the XNOR-popcount sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xnorpop_pkg;

    localparam int VEC_W  = 128;
    localparam int POP_W  = 8;
    localparam int CALC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Bipolar dot product from a match count: matches count +1, mismatches -1.
    // Computed wide; callers truncate to their own result width.
    function automatic logic signed [CALC_W:0] dot_from_pop(
        input logic [CALC_W-1:0] pop,
        input logic [CALC_W-1:0] len
    );
        logic signed [CALC_W:0] pop_x2;
        logic signed [CALC_W:0] bits_total;
        pop_x2     = $signed({pop, 1'b0});
        bits_total = $signed({len[CALC_W-7:0], 7'd0});
        return pop_x2 - bits_total;
    endfunction

endpackage

// File: rtl/xnorpop_dot_sequencer_popcount.sv
// popcount_mimic_circuit: counts matching bit positions (XNOR popcount) of two 128-bit words.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module popcount_mimic_circuit
    import xnorpop_pkg::*;
(
    input  logic [VEC_W-1:0] x,
    input  logic [VEC_W-1:0] y,
    output logic [POP_W-1:0] pop
);

    logic [VEC_W-1:0] match;

    always_comb begin
        match = ~(x ^ y);
        pop   = '0;
        for (int i = 0; i < VEC_W; i++) begin
            pop = pop + POP_W'(match[i]);
        end
    end

endmodule

// File: rtl/xnorpop_dot_sequencer.sv
// Streams len word pairs through one popcount datapath and returns total matches and the +/-1 dot product.
// Latency: result valid two cycles after the final word handshake (one cycle after start for len=0).
// Backpressure: one word per cycle while RUN; result held in DONE until out_ready; abort blocks both ready outputs.
module xnorpop_dot_sequencer
    import xnorpop_pkg::*;
#(
    parameter  int LEN_W = 8,
    localparam int ACC_W = LEN_W + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_x,
    input  logic [VEC_W-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_pop,
    output logic [ACC_W:0]   out_dot,
    output logic             busy
);

    seq_state_t       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat;
    logic [VEC_W-1:0] s1_x;
    logic [VEC_W-1:0] s1_y;
    logic             s1_vld;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [POP_W-1:0] word_pop;
    logic [ACC_W:0]   dot_next;
    logic             start_hs;
    logic             in_hs;
    logic             out_hs;

    popcount_mimic_circuit u_popcount (
        .x   (s1_x),
        .y   (s1_y),
        .pop (word_pop)
    );

    assign start_ready = (state == IDLE) && !abort;
    assign in_ready    = (state == RUN) && (beat < len_q) && !abort;
    assign busy        = (state != IDLE);

    assign start_hs = start && start_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Stage 2: the popcount of the word registered last cycle joins the running sum.
    assign acc_next = acc + (s1_vld ? ACC_W'(word_pop) : ACC_W'(0));
    assign dot_next = (ACC_W+1)'(dot_from_pop(CALC_W'(acc_next), CALC_W'(len_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            beat      <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_vld    <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_pop   <= '0;
            out_dot   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            beat      <= '0;
            s1_vld    <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_vld <= in_hs;
            acc    <= acc_next;
            if (in_hs) begin
                s1_x <= in_x;
                s1_y <= in_y;
                beat <= beat + LEN_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start_hs) begin
                        len_q <= start_len;
                        beat  <= '0;
                        acc   <= '0;
                        if (start_len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_pop   <= '0;
                            out_dot   <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_hs && (beat == len_q - LEN_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out_pop   <= acc_next;
                    out_dot   <= dot_next;
                end
                DONE: begin
                    if (out_hs) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xnorpop_dot_sequencer.sv
// Directed plus randomized jobs against a match-count reference model built from the word queues.
module tb_xnorpop_dot_sequencer;

    localparam int LEN_W = 8;
    localparam int ACC_W = LEN_W + 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             abort;
    logic             start;
    logic             start_ready;
    logic [LEN_W-1:0] start_len;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_x;
    logic [127:0]     in_y;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_pop;
    logic [ACC_W:0]   out_dot;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic [127:0] wx[$];
    logic [127:0] wy[$];

    xnorpop_dot_sequencer #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort       (abort),
        .start       (start),
        .start_ready (start_ready),
        .start_len   (start_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pop     (out_pop),
        .out_dot     (out_dot),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: count of equal bit positions summed over the first n queued word pairs.
    function automatic int ref_pop(input int n);
        int p = 0;
        for (int i = 0; i < n; i++) p += $countones(~(wx[i] ^ wy[i]));
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int n);
        wx.delete();
        wy.delete();
        for (int i = 0; i < n; i++) begin
            logic [127:0] a;
            logic [127:0] m;
            a = {$urandom, $urandom, $urandom, $urandom};
            m = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
            wx.push_back(a);
            wy.push_back(a ^ m);
        end
    endtask

    task automatic fill_const(input int n, input logic [127:0] x, input logic [127:0] y);
        wx.delete();
        wy.delete();
        for (int i = 0; i < n; i++) begin
            wx.push_back(x);
            wy.push_back(y);
        end
    endtask

    task automatic start_job(input int len);
        start_len = LEN_W'(len);
        start     = 1'b1;
        #1;
        check("start_ready_idle", start_ready, 1);
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int wait_c = 0;
            in_valid = 1'b0;
            repeat ($urandom_range(gap, 0)) step();
            in_valid = 1'b1;
            in_x     = wx[i];
            in_y     = wy[i];
            #1;
            while (!in_ready && wait_c < 20) begin
                step();
                #1;
                wait_c++;
            end
            check("in_ready_run", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input int len, input int hold);
        int p = ref_pop(len);
        int d = 2 * p - 128 * len;
        if (len != 0) begin
            #1;
            check("in_ready_after_last", in_ready, 0);
            check("out_valid_in_drain", out_valid, 0);
            check("busy_in_drain", busy, 1);
            step();
        end
        check("out_valid_latency", out_valid, 1);
        check("out_pop", out_pop, p);
        check("out_dot", $signed(out_dot), d);
        for (int k = 0; k < hold; k++) begin
            start     = 1'b1;
            start_len = LEN_W'($urandom_range(1, 5));
            #1;
            check("start_ready_in_done", start_ready, 0);
            step();
            check("out_valid_hold", out_valid, 1);
            check("out_pop_hold", out_pop, p);
            check("out_dot_hold", $signed(out_dot), d);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_take", out_valid, 0);
        check("out_pop_kept", out_pop, p);
        check("start_ready_back", start_ready, 1);
    endtask

    task automatic do_job(input int len, input int gap, input int hold);
        start_job(len);
        feed(len, gap);
        finish_job(len, hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
        start_len = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_pop", out_pop, 0);
        check("rst_out_dot", $signed(out_dot), 0);
        rst_n = 1'b1;
        step();

        // Single-word full match, then full mismatch.
        fill_const(1, {128{1'b1}}, {128{1'b1}});
        do_job(1, 0, 0);
        fill_const(1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, ~128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        do_job(1, 0, 0);

        // Three words scoring 128, 0, 64 with two-cycle valid gaps.
        wx.delete();
        wy.delete();
        wx.push_back({128{1'b1}}); wy.push_back({128{1'b1}});
        wx.push_back({128{1'b1}}); wy.push_back({128{1'b0}});
        wx.push_back({128{1'b1}}); wy.push_back({{64{1'b0}}, {64{1'b1}}});
        start_job(3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            step();
            step();
            in_valid = 1'b1;
            in_x     = wx[i];
            in_y     = wy[i];
            #1;
            check("in_ready_gapped", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        finish_job(3, 0);

        // Zero-length job: result the cycle after start, words never accepted.
        wx.delete();
        wy.delete();
        in_valid = 1'b1;
        start_job(0);
        #1;
        check("len0_in_ready", in_ready, 0);
        in_valid = 1'b0;
        finish_job(0, 0);

        // Result held under backpressure for five cycles, then a fresh job.
        fill_rand(2);
        do_job(2, 1, 5);
        fill_rand(1);
        do_job(1, 0, 0);

        // Abort after two of four words; no result may appear and nothing may leak forward.
        fill_rand(4);
        start_job(4);
        feed(2, 1);
        abort    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_x     = wx[2];
        in_y     = wy[2];
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_start_ready", start_ready, 0);
        step();
        abort    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_start_ready_after", start_ready, 1);
        for (int k = 0; k < 3; k++) begin
            check("abort_out_valid", out_valid, 0);
            step();
        end
        fill_const(1, {128{1'b1}}, {128{1'b1}});
        do_job(1, 0, 0);

        // Longest job, all words matching.
        fill_const(255, {4{32'hdead_beef}}, {4{32'hdead_beef}});
        do_job(255, 0, 0);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            int len;
            len = $urandom_range(1, 9);
            fill_rand(len);
            do_job(len, 2, $urandom_range(0, 3));
        end

        // Reset in the middle of a job.
        fill_rand(5);
        start_job(5);
        feed(2, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", start_ready, 1);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_pop", out_pop, 0);
        check("midrst_out_dot", $signed(out_dot), 0);
        step();
        rst_n = 1'b1;
        step();
        fill_rand(3);
        do_job(3, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xnorpop_dot_sequencer.md
Name: xnorpop_dot_sequencer

Overview:
Sequences multi-word binarized (XNOR-popcount) dot products through one shared 128-bit popcount_mimic_circuit instance. Accepts a job command with a word count and streams word pairs through a valid/ready handshake, one pair per cycle. It accumulates the per-word popcounts, then returns the total popcount and the signed ±1 dot product. It sits between the BNN layer scheduler (command side) and the activation buffer (stream side).

Parameters:
LEN_W, 8, width of the job length; maximum job is 2^LEN_W-1 words.
ACC_W, LEN_W+8 (localparam, derived), accumulator width; sized so it cannot overflow.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
abort  input  1  synchronous job cancel
start  input  1  job command valid
start_ready  output  1  job command accepted when start&&start_ready
start_len  input  LEN_W  number of 128-bit word pairs in the job
in_valid  input  1  word pair valid
in_ready  output  1  word pair accepted when in_valid&&in_ready
in_x  input  128  activation word
in_y  input  128  weight word
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid&&out_ready
out_pop  output  ACC_W  total matching bits
out_dot  output  ACC_W+1  signed dot product, 2*out_pop - 128*len
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, counters and accumulator=0, stage register invalid, out_valid=0, out_pop=0, out_dot=0, in_ready=0, busy=0, start_ready=1.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_ready=1, in_ready=0.
  - On start: latch start_len, clear accumulator and beat counter.
  - Next state is RUN if start_len!=0, else DONE with pop=0, dot=0.
- RUN:
  - in_ready=1 while beat counter < len; beat counter increments on each in handshake.
  - in_valid gaps are allowed.
  - A handshake registers in_x/in_y into the stage-1 registers with a valid flag.
  - Stage 2: popcount_mimic_circuit output (8 bits, 0..128) is added to the accumulator whenever the stage-1 valid flag is set.
  - The handshake that accepts the final word moves the FSM to DRAIN; in_ready is 0 from the next cycle.
- DRAIN: one cycle; the final stage-1 word is accumulated; next state DONE.
- Latency: final in handshake in cycle c; DRAIN in cycle c+1; out_valid=1 in cycle c+2.
  - For len=0: start accepted in cycle c, out_valid=1 in cycle c+1.
- DONE:
  - out_valid=1; out_pop and out_dot are registered and held stable until out_ready.
  - start_ready=0 and in_ready=0.
  - On out_ready, next state IDLE; out_valid drops the following cycle.
  - out_pop/out_dot keep their last values after the transfer.
- Arithmetic:
  - Accumulator is unsigned ACC_W bits.
  - out_dot = {acc,1'b0} - (len<<7), computed at ACC_W+1 bits signed; range ±128*len.
- abort (synchronous, any state):
  - Next state IDLE; stage-1 valid cleared; accumulator, beat counter and out_valid cleared.
  - abort has priority over start, in handshake and out_ready in the same cycle.
  - in_ready and start_ready are both 0 in any cycle where abort=1.
- in_valid outside RUN is ignored; no words are accepted beyond len.
- rst_n asserted mid-job: immediate return to the reset values; the job is lost.

Decomposition:
- Package xnorpop_pkg holds:
  - constants VEC_W=128 and POP_W=8;
  - state typedef/encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - function dot_from_pop(pop, len).
- Sub-module: the existing popcount_mimic_circuit, instantiated once as the stage-2 combinational datapath. The sequencer itself is one module (FSM, beat counter, stage-1 registers, accumulator, output registers).

Test Plan:
1. len=1, in_x=in_y=all ones -> out_pop=128, out_dot=+128, out_valid exactly 2 cycles after the handshake; repeat with in_x=~in_y -> out_pop=0, out_dot=-128.
2. len=3, pops 128, 0, 64 (words 0x..FF vs 0x..FF; complement; upper 64 bits differ), in_valid low 2 cycles between words -> out_pop=192, out_dot=0; in_ready drops after the 3rd handshake.
3. len=0 -> out_valid the cycle after start; out_pop=0, out_dot=0; no in handshake occurs.
4. len=2 result with out_ready low for 5 cycles -> out_pop/out_dot stable, start_ready=0, start ignored; after out_ready pulse, IDLE and a new start is accepted.
5. len=4, abort after 2 words -> next cycle IDLE, out_valid never set; a new len=1 all-match job returns 128/+128 with no residue.
6. len=255 all-match -> out_pop=32640, out_dot=+32640, no overflow; then rst_n low mid-job on a second job -> all outputs at reset values, start_ready=1.
